slice_monitor: RTL
==================

# slice_monitor

Parametrised, clocked successor to the combinational bus-slice submodule used in the hierarchy/instance diagnostics. It extracts a parameter-selected bit field from a wider input bus and registers it. It tracks value changes on that field with a saturating change counter and a sticky per-bit toggle mask. It is instantiated several times with different parameter overrides, so that per-instance parameter resolution and coverage are exercised on real sequential logic.

## Interface
Parameters:
- IN_WIDTH, 3, width of in_data
- SLICE_LSB, 0, lowest in_data bit of the extracted field
- SLICE_WIDTH, 2, width of the extracted field; SLICE_LSB+SLICE_WIDTH <= IN_WIDTH required, and the block must not be elaborated otherwise
- CNT_WIDTH, 4, width of change_count

Ports:
- Clocking: one clock, `clock`; reset is synchronous and active-high, named `reset`.
- clock  input  1  rising-edge clock for all state
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_data carries a sample this cycle
- in_data  input  IN_WIDTH  source bus
- hold  input  1  when high, samples are ignored (not accepted)
- clear  input  1  clears change_count, saturated and toggled
- out_slice  output  SLICE_WIDTH  last accepted field value
- out_valid  output  1  one-cycle pulse: out_slice was just updated
- changed  output  1  one-cycle pulse: accepted value differed from previous accepted value
- change_count  output  CNT_WIDTH  number of changes since reset/clear, saturating
- saturated  output  1  sticky: change_count reached all-ones
- toggled  output  SLICE_WIDTH  sticky per-bit OR of changed bits

## Operation
- Accept condition: in_valid & ~hold & ~reset. Field = in_data[SLICE_LSB+SLICE_WIDTH-1 : SLICE_LSB].
- State machine with two states:
  - UNPRIMED is the state after reset. The first accept loads out_slice, pulses out_valid, leaves changed low, and moves to PRIMED.
  - In PRIMED, each accept loads out_slice and pulses out_valid. diff = field ^ out_slice. changed = |diff, and toggled |= diff.
- Counter behaviour:
  - On changed, change_count increments by 1 if it is not all-ones.
  - saturated sets when the count becomes all-ones and stays set.
  - The counter never wraps.
- clear (synchronous):
  - Zeroes change_count, saturated and toggled in the same edge.
  - It does not affect out_slice, out_valid, changed or state.
  - clear together with a changing accept: changed still pulses, but count, saturated and toggled end at 0, because clear wins.
- hold together with in_valid: the sample is dropped, all state is kept, and out_valid and changed stay low.
- An accept of a value equal to out_slice pulses out_valid only.

## Timing
- Reset values: out_slice=0, out_valid=0, changed=0, change_count=0, saturated=0, toggled=0, state=UNPRIMED.
- Latency: a sample accepted at edge k appears on out_slice, with out_valid/changed high, during the cycle after edge k. This is a 1-cycle latency, and all outputs are registered.
- out_valid and changed are high for exactly one cycle per accept. Back-to-back accepts give consecutive pulses with no bubble requirement.
- Reset asserted mid-stream takes priority over accept and clear on the same edge. All outputs return to reset values at that edge, and the next accept is treated as the first (no changed pulse).
- No combinational path from any input to any output.

## Test plan
- Defaults, reset, then accepts 3'b000, 3'b001, 3'b100 on consecutive cycles:
  - out_slice goes 00, 01, 00.
  - changed goes 0, 1, 1.
  - change_count ends at 2, toggled=2'b01, saturated=0.
- SLICE_LSB=1, SLICE_WIDTH=2, IN_WIDTH=3: accept 3'b110 -> out_slice=2'b11, changed=0 (first sample). Then accept 3'b010 -> out_slice=2'b01, changed=1, toggled=2'b10.
- CNT_WIDTH=2, alternating 3'b000/3'b011 for 6 accepts: change_count goes 0,1,2,3,3,3, and saturated rises on the edge where the count reaches 3 and stays 1. Then clear -> count=0, saturated=0, toggled=0, out_slice unchanged.
- hold=1 with in_valid=1 and in_data=3'b011 after out_slice=00: out_valid=0, changed=0, and all outputs unchanged.
- clear asserted on the same edge as a changing accept (00 -> 11): out_slice=11 and changed=1, but change_count=0 and toggled=00.
- Reset asserted mid-stream (count=2), then accept 3'b001: all outputs zero after the reset edge, then out_slice=01, changed=0, count=0.

Source files
------------

// File: rtl/slice_monitor.sv
// slice_monitor: registers a parameter-selected field of in_data, counts value
// changes with a saturating counter and keeps a sticky per-bit toggle mask.
module slice_monitor #(
    parameter int IN_WIDTH    = 3,
    parameter int SLICE_LSB   = 0,
    parameter int SLICE_WIDTH = 2,
    parameter int CNT_WIDTH   = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [IN_WIDTH-1:0]    in_data,
    input  logic                   hold,
    input  logic                   clear,
    output logic [SLICE_WIDTH-1:0] out_slice,
    output logic                   out_valid,
    output logic                   changed,
    output logic [CNT_WIDTH-1:0]   change_count,
    output logic                   saturated,
    output logic [SLICE_WIDTH-1:0] toggled
);

    // Refuse to build a field that would run off the top of the source bus.
    if (SLICE_LSB < 0 || SLICE_WIDTH < 1 || CNT_WIDTH < 1 ||
        SLICE_LSB + SLICE_WIDTH > IN_WIDTH) begin : g_bad_params
        $error("slice_monitor: field [%0d +: %0d] does not fit IN_WIDTH=%0d",
               SLICE_LSB, SLICE_WIDTH, IN_WIDTH);
    end

    typedef enum logic [0:0] {
        ST_UNPRIMED = 1'b0,
        ST_PRIMED   = 1'b1
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_e                 state_q, state_d;
    logic [SLICE_WIDTH-1:0] slice_q, slice_d;
    logic                   valid_q, valid_d;
    logic                   changed_q, changed_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   sat_q, sat_d;
    logic [SLICE_WIDTH-1:0] toggled_q, toggled_d;

    logic                   accept_s;
    logic [SLICE_WIDTH-1:0] field_s;
    logic [SLICE_WIDTH-1:0] diff_s;
    logic                   unused_in_s;

    assign accept_s    = in_valid & ~hold;
    assign field_s     = in_data[SLICE_LSB +: SLICE_WIDTH];
    assign diff_s      = field_s ^ slice_q;
    // Bits outside the field are intentionally ignored.
    assign unused_in_s = ^in_data;

    // Next-state logic: priming, change detection, saturating count, clear.
    always_comb begin
        state_d   = state_q;
        slice_d   = slice_q;
        valid_d   = 1'b0;
        changed_d = 1'b0;
        count_d   = count_q;
        toggled_d = toggled_q;
        case (state_q)
            ST_UNPRIMED: begin
                if (accept_s) begin
                    slice_d = field_s;
                    valid_d = 1'b1;
                    state_d = ST_PRIMED;
                end else begin
                    state_d = ST_UNPRIMED;
                end
            end
            ST_PRIMED: begin
                if (accept_s) begin
                    slice_d   = field_s;
                    valid_d   = 1'b1;
                    changed_d = |diff_s;
                    toggled_d = toggled_q | diff_s;
                    if ((|diff_s) && (count_q != CNT_MAX)) begin
                        count_d = count_q + CNT_WIDTH'(1);
                    end else begin
                        count_d = count_q;
                    end
                end else begin
                    state_d = ST_PRIMED;
                end
            end
            default: begin
                state_d = ST_UNPRIMED;
            end
        endcase

        sat_d = sat_q | (count_d == CNT_MAX);

        // clear wins over any concurrent update of the statistics.
        if (clear) begin
            count_d   = {CNT_WIDTH{1'b0}};
            sat_d     = 1'b0;
            toggled_d = {SLICE_WIDTH{1'b0}};
        end else begin
            sat_d = sat_d;
        end
    end

    // State register; reset overrides both accept and clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_UNPRIMED;
            slice_q   <= {SLICE_WIDTH{1'b0}};
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            count_q   <= {CNT_WIDTH{1'b0}};
            sat_q     <= 1'b0;
            toggled_q <= {SLICE_WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            slice_q   <= slice_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
            toggled_q <= toggled_d;
        end
    end

    assign out_slice    = slice_q;
    assign out_valid    = valid_q;
    assign changed      = changed_q;
    assign change_count = count_q;
    assign saturated    = sat_q;
    assign toggled      = toggled_q;

endmodule
